// File: rtl/speck_encrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module   : speck_encrypt_iterative
// Brief    : SPECK 128/128 encryption, one round per clock, key schedule
//            expanded alongside the data rounds.
// Revision : 1.0 - initial release
// ============================================================================

module speck_encrypt_iterative #(
  parameter int NR_ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         signal_start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         finished,
  output logic         busy,
  output logic [3:0]   state_response
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [5:0] LAST_ROUND = 6'(NR_ROUNDS - 1);

  logic [1:0]   state_q, state_d;
  logic [63:0]  x_q, x_d;
  logic [63:0]  y_q, y_d;
  logic [63:0]  k_q, k_d;
  logic [63:0]  l_q, l_d;
  logic [5:0]   ctr_q, ctr_d;
  logic [127:0] ct_q, ct_d;

  logic [63:0]  round_x;
  logic [63:0]  round_y;
  logic [63:0]  round_l;
  logic [63:0]  round_k;
  logic         last_round;

  // Data round and key-schedule round share the same ROR8/add/ROL3 shape.
  always_comb begin
    round_x    = ({x_q[7:0], x_q[63:8]} + y_q) ^ k_q;
    round_y    = {y_q[60:0], y_q[63:61]} ^ round_x;
    round_l    = ({l_q[7:0], l_q[63:8]} + k_q) ^ {58'd0, ctr_q};
    round_k    = {k_q[60:0], k_q[63:61]} ^ round_l;
    last_round = (ctr_q == LAST_ROUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 64'd0;
      y_q     <= 64'd0;
      k_q     <= 64'd0;
      l_q     <= 64'd0;
      ctr_q   <= 6'd0;
      ct_q    <= 128'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      l_q     <= l_d;
      ctr_q   <= ctr_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (signal_start) state_d = S_ROUND;
      S_ROUND: if (last_round)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    k_d   = k_q;
    l_d   = l_q;
    ctr_d = ctr_q;
    ct_d  = ct_q;
    case (state_q)
      S_IDLE: begin
        if (signal_start) begin
          x_d   = plaintext[127:64];
          y_d   = plaintext[63:0];
          k_d   = key[127:64];
          l_d   = key[63:0];
          ctr_d = 6'd0;
        end
      end
      S_ROUND: begin
        x_d = round_x;
        y_d = round_y;
        k_d = round_k;
        l_d = round_l;
        if (last_round) begin
          ct_d = {round_x, round_y};
        end else begin
          ctr_d = ctr_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  // The DONE state lasts exactly one cycle, so it doubles as the finished pulse.
  always_comb begin
    busy           = (state_q != S_IDLE);
    finished       = (state_q == S_DONE);
    state_response = {2'b00, state_q};
  end

  assign ciphertext = ct_q;

endmodule

`default_nettype wire

// File: tb/tb_speck_encrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_speck_encrypt_iterative
// Brief    : Self-checking bench for speck_encrypt_iterative.
// Revision : 1.0 - initial release
// ============================================================================

module tb_speck_encrypt_iterative;

  localparam int NR = 32;

  localparam logic [127:0] KEY_STD = 128'h0706050403020100_0f0e0d0c0b0a0908;
  localparam logic [127:0] PT_STD  = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] CT_STD  = 128'ha65d985179783265_7860fedf5c570d18;
  localparam logic [127:0] KEY_RT  = 128'h472d4b6150645367753778214125442a;
  localparam logic [127:0] CT_RT   = 128'h59280828b8d8d0403f862cf52b4e2e67;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         signal_start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic [127:0] ciphertext;
  logic         finished;
  logic         busy;
  logic [3:0]   state_response;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  speck_encrypt_iterative #(.NR_ROUNDS(NR)) dut (
    .clk            (clk),
    .rst            (rst),
    .signal_start   (signal_start),
    .key            (key),
    .plaintext      (plaintext),
    .ciphertext     (ciphertext),
    .finished       (finished),
    .busy           (busy),
    .state_response (state_response)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] kk, input logic [127:0] pp);
    logic [63:0] x, y, k, l;
    x = pp[127:64]; y = pp[63:0]; k = kk[127:64]; l = kk[63:0];
    for (int i = 0; i < NR; i++) begin
      x = (ror(x, 8) + y) ^ k;
      y = rol(y, 3) ^ x;
      l = (ror(l, 8) + k) ^ 64'(i);
      k = rol(k, 3) ^ l;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] cc, input logic [127:0] kk);
    logic [63:0] x, y, k, l;
    logic [63:0] rk [NR];
    k = kk[127:64]; l = kk[63:0];
    for (int i = 0; i < NR; i++) begin
      rk[i] = k;
      l = (ror(l, 8) + k) ^ 64'(i);
      k = rol(k, 3) ^ l;
    end
    x = cc[127:64]; y = cc[63:0];
    for (int i = NR - 1; i >= 0; i--) begin
      y = ror(y ^ x, 3);
      x = rol((x ^ rk[i]) - y, 8);
    end
    return {x, y};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: cycles elapsed since the accepting edge drive every output.
  bit           m_active = 1'b0;
  int           m_t = 0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_ct = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_ct     <= '0;
    end else if (!m_active) begin
      if (signal_start) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_pend   <= enc(key, plaintext);
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == NR) m_ct <= m_pend;
      if (m_t + 1 == NR + 1) m_active <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state_response", 128'(state_response),
            m_active ? ((m_t < NR) ? 128'd1 : 128'd2) : 128'd0);
      check("busy", 128'(busy), 128'(m_active));
      check("finished", 128'(finished), 128'(m_active && m_t == NR));
      check("ciphertext", ciphertext, m_ct);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [127:0] kk, input logic [127:0] pp,
                        output logic [127:0] ct, output int lat);
    key = kk; plaintext = pp; signal_start = 1'b1;
    tick();
    signal_start = 1'b0;
    lat = 0;
    while (!finished && lat < 200) begin tick(); lat++; end
    ct = ciphertext;
    tick();
    tick();
  endtask

  task automatic wait_finish(output logic [127:0] ct, output int lat);
    lat = 0;
    while (!finished && lat < 200) begin tick(); lat++; end
    ct = ciphertext;
    tick();
    tick();
  endtask

  initial begin
    logic [127:0] ct, kk, pp, pt_rt;
    int lat, nf, cnt, steps;
    int fpos [3];
    logic [127:0] fct [3];

    // Pin the model to the published vector
    check("model_enc_std", enc(KEY_STD, PT_STD), CT_STD);
    check("model_dec_std", dec(CT_STD, KEY_STD), PT_STD);

    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_state", 128'(state_response), 128'd0);
    check("reset_ct", ciphertext, 128'd0);
    check("reset_busy", 128'(busy), 128'd0);

    // Standard vector
    run_op(KEY_STD, PT_STD, ct, lat);
    check("std_latency", 128'(lat), 128'(NR));
    check("std_ct", ct, CT_STD);

    // Held start: accepts every NR+2 cycles
    key = KEY_STD; plaintext = PT_STD; signal_start = 1'b1;
    nf = 0; steps = 0;
    while (nf < 3 && steps < 300) begin
      tick(); steps++;
      if (finished) begin fpos[nf] = steps; fct[nf] = ciphertext; nf++; end
    end
    signal_start = 1'b0;
    check("held_count", 128'(nf), 128'd3);
    if (nf == 3) begin
      check("held_first", 128'(fpos[0]), 128'(NR + 1));
      check("held_period1", 128'(fpos[1] - fpos[0]), 128'(NR + 2));
      check("held_period2", 128'(fpos[2] - fpos[1]), 128'(NR + 2));
      for (int i = 0; i < 3; i++) check("held_ct", fct[i], CT_STD);
    end
    cnt = 0;
    repeat (40) begin tick(); if (finished) cnt++; end
    check("held_no_extra", 128'(cnt), 128'd0);

    // Stray start at round 10 with another plaintext
    key = KEY_STD; plaintext = PT_STD; signal_start = 1'b1;
    tick();
    signal_start = 1'b0;
    repeat (10) tick();
    plaintext = ~PT_STD; signal_start = 1'b1;
    tick();
    signal_start = 1'b0; plaintext = PT_STD;
    wait_finish(ct, lat);
    check("stray_start_ct", ct, CT_STD);
    cnt = 0;
    repeat (40) begin tick(); if (finished) cnt++; end
    check("stray_no_extra", 128'(cnt), 128'd0);

    // Input isolation
    key = KEY_STD; plaintext = PT_STD; signal_start = 1'b1;
    tick();
    signal_start = 1'b0;
    key = '1; plaintext = '1;
    wait_finish(ct, lat);
    check("isolation_ct", ct, CT_STD);

    // Reset mid-operation at round 15
    key = KEY_STD; plaintext = PT_STD; signal_start = 1'b1;
    tick();
    signal_start = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", 128'(state_response), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_ct", ciphertext, 128'd0);
    cnt = 0;
    repeat (40) begin tick(); if (finished) cnt++; end
    check("midrst_no_finish", 128'(cnt), 128'd0);
    run_op(KEY_STD, PT_STD, ct, lat);
    check("after_rst_ct", ct, CT_STD);

    // Reset and start on the same edge
    rst = 1'b1; signal_start = 1'b1;
    tick();
    rst = 1'b0; signal_start = 1'b0;
    check("collide_state", 128'(state_response), 128'd0);
    tick();
    check("collide_idle", 128'(state_response), 128'd0);
    check("collide_busy", 128'(busy), 128'd0);

    // Round trip against the decrypt direction
    pt_rt = dec(CT_RT, KEY_RT);
    run_op(KEY_RT, pt_rt, ct, lat);
    check("roundtrip_ct", ct, CT_RT);

    for (int i = 0; i < 16; i++) begin
      kk = {$urandom, $urandom, $urandom, $urandom};
      pp = {$urandom, $urandom, $urandom, $urandom};
      run_op(kk, pp, ct, lat);
      check("rand_latency", 128'(lat), 128'(NR));
      check("rand_roundtrip", dec(ct, kk), pp);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/speck_encrypt_iterative.md
# speck_encrypt_iterative

Iterative SPECK 128/128 encryption core: one round per clock with the key schedule expanded on the fly, so no round-key cache is needed. It is the encrypt-side counterpart of the unrolled `round_decrypt`/`key_schedule` decryption chain. It uses the same 128-bit key, block and word packing, so its ciphertext feeds that chain directly. A start/finished pulse handshake matches the existing round and key-schedule blocks.

## Interface
- `NR_ROUNDS`, default 32 (equals `` `NR_ROUNDS ``). Number of rounds; legal range 1..64.
- `clk` input 1: the single clock. All logic uses the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `signal_start` input 1: request pulse. Sampled only in IDLE.
- `key` input 128: `[127:64]` = k0 (first round key word); `[63:0]` = l0.
- `plaintext` input 128: `[127:64]` = x word; `[63:0]` = y word.
- `ciphertext` output 128: result, with the same x/y packing. Registered; held until the next completion or reset.
- `finished` output 1: one-cycle completion pulse.
- `busy` output 1: high whenever the state is not IDLE.
- `state_response` output 4: current state code. IDLE=0, ROUND=1, DONE=2.

## Operation
- Registers:
  - x, y, k, l: 64 bits each.
  - Round counter `ctr`: 6 bits.
  - State register.
- IDLE:
  - If `signal_start`=1: load x/y from `plaintext` and k/l from `key`, clear `ctr`, go to ROUND.
  - Otherwise hold.
- ROUND, each cycle, with i=`ctr` and all additions mod 2^64:
  - x' = (ROR(x,8) + y) XOR k
  - y' = ROL(y,3) XOR x'
  - l' = (ROR(l,8) + k) XOR zero-extended i
  - k' = ROL(k,3) XOR l'
- ROUND, end of round:
  - If i = NR_ROUNDS-1: write {x',y'} into `ciphertext`, set `finished`=1, go to DONE. The k/l update on this final cycle is don't-care.
  - Otherwise increment `ctr` and stay in ROUND.
- DONE: clear `finished`, go to IDLE. `signal_start` is ignored in DONE.
- `signal_start` in ROUND or DONE is ignored. It is not queued and raises no error.
- `key` and `plaintext` are sampled only on the accepting edge. Later changes have no effect on the operation in flight.
- Reset:
  - State goes to IDLE; `ctr`, x, y, k, l and `ciphertext` go to 0.
  - `finished`=0, `busy`=0, `state_response`=0.
  - Reset mid-operation aborts it. No `finished` pulse is produced and `ciphertext` reads 0.
  - `rst` has priority over `signal_start` on the same edge.

## Timing
- Edge N: `signal_start`=1 sampled in IDLE; state becomes ROUND and `busy` rises after N.
- Edges N+1 .. N+NR_ROUNDS: rounds 0 .. NR_ROUNDS-1.
- Edge N+NR_ROUNDS:
  - `ciphertext` updated.
  - `finished` high for exactly the cycle N+NR_ROUNDS .. N+NR_ROUNDS+1.
  - `state_response`=2.
- Edge N+NR_ROUNDS+1: IDLE, `busy`=0.
- Earliest next accept: edge N+NR_ROUNDS+2. Period is NR_ROUNDS+2 cycles; latency start-to-finished is NR_ROUNDS (34 cycles period, 32 latency for the default).
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- Standard vector, default NR_ROUNDS:
  - Stimulus: key = 0x0706050403020100_0f0e0d0c0b0a0908; plaintext = 0x6c61766975716520_7469206564616d20; pulse `signal_start` for one cycle.
  - Required: `finished` exactly 32 cycles after the accepting edge; ciphertext = 0xa65d985179783265_7860fedf5c570d18.
  - Required: `state_response` sequence 0, 1 (32 cycles), 2, 0.
- Busy-start ignore:
  - Stimulus: hold `signal_start`=1 continuously.
  - Required: accepts every 34 cycles; results identical to the standard vector; no extra `finished` pulses.
  - Stimulus: one `signal_start` pulse at round 10 with a different plaintext.
  - Required: no effect on the result.
- Input isolation: change `key` and `plaintext` to 0xFFFF… one cycle after accept → ciphertext still equals the standard-vector result.
- Reset mid-operation:
  - Stimulus: assert `rst` for one cycle at round 15.
  - Required: next cycle shows `state_response`=0, `busy`=0 and `ciphertext`=0, and no `finished` pulse follows.
  - Stimulus: a fresh start after reset.
  - Required: the standard-vector result.
- Reset/start collision: `rst`=1 and `signal_start`=1 on the same edge → remains IDLE; no operation starts.
- Round-trip with the decrypt chain:
  - Stimulus: feed ciphertext 0x59280828b8d8d0403f862cf52b4e2e67 with the bench key 0x472d4b6150645367753778214125442a into the existing decrypt chain. Take its recovered plaintext and encrypt it with this block.
  - Required: the output bit-exactly equals 0x59280828b8d8d0403f862cf52b4e2e67.
  - Also run 16 random key/plaintext pairs through encrypt then decrypt; each must return the original plaintext.
